// File: rtl/conv_job_ctrl_pkg.sv
// Shared widths, state encodings and parameter-check helper for the
// convolution job controller.
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 8
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif

package conv_job_ctrl_pkg;

  localparam int TENSOR_W   = `TENSOR_SIZE;
  localparam int KERNEL_W   = `KERNEL_SIZE;
  localparam int CHANNELS_W = `CHANNELS_SIZE;
  localparam int STRIDE_W   = `STRIDE_SIZE;
  localparam int KNUMS_W    = `KERNEL_NUMS_SIZE;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHECK     = 3'd1;
  localparam state_t ST_CLEAR     = 3'd2;
  localparam state_t ST_PREP      = 3'd3;
  localparam state_t ST_WAIT_TILE = 3'd4;
  localparam state_t ST_ISSUE     = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // Kernel wider than the tensor or any zero field cannot produce a valid job.
  function automatic logic job_params_bad(
    input logic [TENSOR_W-1:0]   t,
    input logic [KERNEL_W-1:0]   k,
    input logic [CHANNELS_W-1:0] c,
    input logic [STRIDE_W-1:0]   s,
    input logic [KNUMS_W-1:0]    n
  );
    return (k == {KERNEL_W{1'b0}}) || (s == {STRIDE_W{1'b0}}) ||
           (c == {CHANNELS_W{1'b0}}) || (n == {KNUMS_W{1'b0}}) || (k > t);
  endfunction

endpackage

// File: rtl/conv_job_ctrl_tile_counter.sv
// Nested tile counter: row is the inner loop (0..ofs), weight block the outer
// loop (0..w_brn-1); exposes next values so the issuer can register them.
module tile_counter
  import conv_job_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic [TENSOR_W-1:0] ofs,
  input  logic [KNUMS_W-1:0]  w_brn,
  output logic [TENSOR_W-1:0] row_nxt,
  output logic [KNUMS_W-1:0]  wb_nxt,
  output logic                last
);

  localparam logic [TENSOR_W-1:0] ROW_ONE = TENSOR_W'(1);
  localparam logic [KNUMS_W-1:0]  WB_ONE  = KNUMS_W'(1);

  logic [TENSOR_W-1:0] row_cnt_r;
  logic [KNUMS_W-1:0]  wb_cnt_r;

  // Last-tile flag and next counter values; the last tile never wraps.
  always_comb begin
    last    = (row_cnt_r == ofs) && (wb_cnt_r == (w_brn - WB_ONE));
    row_nxt = row_cnt_r;
    wb_nxt  = wb_cnt_r;
    if (clear) begin
      row_nxt = {TENSOR_W{1'b0}};
      wb_nxt  = {KNUMS_W{1'b0}};
    end else if (advance && !last) begin
      if (row_cnt_r == ofs) begin
        row_nxt = {TENSOR_W{1'b0}};
        wb_nxt  = wb_cnt_r + WB_ONE;
      end else begin
        row_nxt = row_cnt_r + ROW_ONE;
        wb_nxt  = wb_cnt_r;
      end
    end else begin
      row_nxt = row_cnt_r;
      wb_nxt  = wb_cnt_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_r <= {TENSOR_W{1'b0}};
      wb_cnt_r  <= {KNUMS_W{1'b0}};
    end else begin
      row_cnt_r <= row_nxt;
      wb_cnt_r  <= wb_nxt;
    end
  end

endmodule

// File: rtl/conv_job_ctrl.sv
// Convolution job controller: validates a job, clears and starts parameter
// preparation, then issues tiles row-inner / weight-block-outer.
module conv_job_ctrl
  import conv_job_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [TENSOR_W-1:0]   tensor_size,
  input  logic [KERNEL_W-1:0]   kernel_size,
  input  logic [CHANNELS_W-1:0] channels,
  input  logic [STRIDE_W-1:0]   stride,
  input  logic [KNUMS_W-1:0]    kernel_nums,
  input  logic                  abort,
  output logic                  pp_rstn,
  output logic                  pp_start,
  output logic [TENSOR_W-1:0]   pp_tensor_size,
  output logic [KERNEL_W-1:0]   pp_kernel_size,
  output logic [CHANNELS_W-1:0] pp_channels,
  output logic [STRIDE_W-1:0]   pp_stride,
  output logic [KNUMS_W-1:0]    pp_kernel_nums,
  input  logic                  pp_enable,
  input  logic [TENSOR_W-1:0]   pp_ofs,
  input  logic [KNUMS_W-1:0]    pp_w_brn,
  output logic                  tile_start,
  output logic [TENSOR_W-1:0]   tile_row,
  output logic [KNUMS_W-1:0]    tile_wb,
  input  logic                  tile_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  err_param,
  output logic                  err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t              state_r, state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                clr_cnt_r;
  logic [TENSOR_W-1:0] ofs_r;
  logic [KNUMS_W-1:0]  w_brn_r;
  logic                bad_s, timeout_s, cnt_clear_s, cnt_adv_s, last_s;
  logic [TENSOR_W-1:0] row_nxt_s, tile_row_s;
  logic [KNUMS_W-1:0]  wb_nxt_s, tile_wb_s;
  logic job_ready_s, busy_s, pp_rstn_s, pp_start_s, tile_start_s;
  logic job_done_s, err_param_s, err_timeout_s;

  assign bad_s       = job_params_bad(pp_tensor_size, pp_kernel_size, pp_channels,
                                      pp_stride, pp_kernel_nums);
  assign timeout_s   = (wait_cnt_r == WAIT_LAST);
  assign cnt_clear_s = (state_r == ST_PREP) && pp_enable && !abort;
  assign cnt_adv_s   = (state_r == ST_WAIT_TILE) && tile_done && !abort;

  tile_counter u_tile_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear_s),
    .advance (cnt_adv_s),
    .ofs     (ofs_r),
    .w_brn   (w_brn_r),
    .row_nxt (row_nxt_s),
    .wb_nxt  (wb_nxt_s),
    .last    (last_s)
  );

  // Next-state logic; abort returns any active state to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (job_valid && job_ready) state_nxt_s = ST_CHECK;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (abort || bad_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (abort)          state_nxt_s = ST_IDLE;
        else if (clr_cnt_r) state_nxt_s = ST_PREP;
        else                state_nxt_s = ST_CLEAR;
      end
      ST_PREP: begin
        if (abort)          state_nxt_s = ST_IDLE;
        else if (pp_enable) state_nxt_s = (pp_w_brn == {KNUMS_W{1'b0}}) ? ST_DONE : ST_ISSUE;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_PREP;
      end
      ST_ISSUE: begin
        if (abort) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_WAIT_TILE;
      end
      ST_WAIT_TILE: begin
        if (abort)          state_nxt_s = ST_IDLE;
        else if (tile_done) state_nxt_s = last_s ? ST_DONE : ST_ISSUE;
        else                state_nxt_s = ST_WAIT_TILE;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    job_ready_s   = (state_nxt_s == ST_IDLE);
    busy_s        = (state_nxt_s != ST_IDLE);
    pp_rstn_s     = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_CLEAR);
    pp_start_s    = (state_nxt_s == ST_PREP) || (state_nxt_s == ST_ISSUE) ||
                    (state_nxt_s == ST_WAIT_TILE) || (state_nxt_s == ST_DONE);
    tile_start_s  = (state_nxt_s == ST_ISSUE);
    job_done_s    = (state_nxt_s == ST_DONE);
    err_param_s   = (state_r == ST_CHECK) && !abort && bad_s;
    err_timeout_s = (state_r == ST_PREP) && !abort && !pp_enable && timeout_s;
    if (tile_start_s) begin
      tile_row_s = row_nxt_s;
      tile_wb_s  = wb_nxt_s;
    end else begin
      tile_row_s = tile_row;
      tile_wb_s  = tile_wb;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      wait_cnt_r     <= {WAIT_W{1'b0}};
      clr_cnt_r      <= 1'b0;
      ofs_r          <= {TENSOR_W{1'b0}};
      w_brn_r        <= {KNUMS_W{1'b0}};
      pp_tensor_size <= {TENSOR_W{1'b0}};
      pp_kernel_size <= {KERNEL_W{1'b0}};
      pp_channels    <= {CHANNELS_W{1'b0}};
      pp_stride      <= {STRIDE_W{1'b0}};
      pp_kernel_nums <= {KNUMS_W{1'b0}};
      job_ready      <= 1'b1;
      busy           <= 1'b0;
      pp_rstn        <= 1'b0;
      pp_start       <= 1'b0;
      tile_start     <= 1'b0;
      tile_row       <= {TENSOR_W{1'b0}};
      tile_wb        <= {KNUMS_W{1'b0}};
      job_done       <= 1'b0;
      err_param      <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= (state_r == ST_PREP) ? (wait_cnt_r + WAIT_ONE) : {WAIT_W{1'b0}};
      clr_cnt_r  <= (state_r == ST_CLEAR) ? ~clr_cnt_r : 1'b0;
      if (state_r == ST_IDLE && job_valid && job_ready) begin
        pp_tensor_size <= tensor_size;
        pp_kernel_size <= kernel_size;
        pp_channels    <= channels;
        pp_stride      <= stride;
        pp_kernel_nums <= kernel_nums;
      end
      if (cnt_clear_s) begin
        ofs_r   <= pp_ofs;
        w_brn_r <= pp_w_brn;
      end
      job_ready   <= job_ready_s;
      busy        <= busy_s;
      pp_rstn     <= pp_rstn_s;
      pp_start    <= pp_start_s;
      tile_start  <= tile_start_s;
      tile_row    <= tile_row_s;
      tile_wb     <= tile_wb_s;
      job_done    <= job_done_s;
      err_param   <= err_param_s;
      err_timeout <= err_timeout_s;
    end
  end

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Directed bench for conv_job_ctrl with a behavioural preparation block
// (S2P_SIZE=8) and hand-sequenced tile_done responses.
module tb_conv_job_ctrl;
  import conv_job_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0, abort = 1'b0, tile_done = 1'b0;
  logic [TENSOR_W-1:0]   tensor_size = '0;
  logic [KERNEL_W-1:0]   kernel_size = '0;
  logic [CHANNELS_W-1:0] channels = '0;
  logic [STRIDE_W-1:0]   stride = '0;
  logic [KNUMS_W-1:0]    kernel_nums = '0;
  logic job_ready, pp_rstn, pp_start, tile_start, busy, job_done, err_param, err_timeout;
  logic [TENSOR_W-1:0]   pp_tensor_size, tile_row, pp_ofs;
  logic [KERNEL_W-1:0]   pp_kernel_size;
  logic [CHANNELS_W-1:0] pp_channels;
  logic [STRIDE_W-1:0]   pp_stride;
  logic [KNUMS_W-1:0]    pp_kernel_nums, tile_wb, pp_w_brn;
  logic                  pp_enable;
  logic prep_allow = 1'b1, force_wbrn0 = 1'b0;
  logic [3:0] prep_cnt;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  conv_job_ctrl #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
    .stride(stride), .kernel_nums(kernel_nums), .abort(abort),
    .pp_rstn(pp_rstn), .pp_start(pp_start), .pp_tensor_size(pp_tensor_size),
    .pp_kernel_size(pp_kernel_size), .pp_channels(pp_channels), .pp_stride(pp_stride),
    .pp_kernel_nums(pp_kernel_nums), .pp_enable(pp_enable), .pp_ofs(pp_ofs),
    .pp_w_brn(pp_w_brn), .tile_start(tile_start), .tile_row(tile_row),
    .tile_wb(tile_wb), .tile_done(tile_done), .busy(busy), .job_done(job_done),
    .err_param(err_param), .err_timeout(err_timeout)
  );

  // Preparation block: four cycles after start, report ofs=(T-K)/S and w_brn=ceil(N/8).
  always @(posedge clk) begin
    if (rst || !pp_rstn || !pp_start) begin
      prep_cnt  <= 4'd0;
      pp_enable <= 1'b0;
      pp_ofs    <= '0;
      pp_w_brn  <= '0;
    end else if (prep_allow && !pp_enable) begin
      prep_cnt <= prep_cnt + 4'd1;
      if (prep_cnt == 4'd3) begin
        pp_enable <= 1'b1;
        pp_ofs    <= TENSOR_W'((int'(pp_tensor_size) - int'(pp_kernel_size)) / int'(pp_stride));
        pp_w_brn  <= force_wbrn0 ? '0 : KNUMS_W'((int'(pp_kernel_nums) + 7) / 8);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_job(input int t, input int k, input int c, input int s, input int n);
    job_valid   = 1'b1;
    tensor_size = TENSOR_W'(t);
    kernel_size = KERNEL_W'(k);
    channels    = CHANNELS_W'(c);
    stride      = STRIDE_W'(s);
    kernel_nums = KNUMS_W'(n);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_tile_start();
    int n = 0;
    while (tile_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tile_start_seen", tile_start, 1);
  endtask

  // Walk the expected tile order; abort_idx selects the tile whose wait is aborted.
  task automatic run_tiles(input int rows, input int wbs, input int abort_idx, input bit with_done);
    int idx = 0;
    for (int wb = 0; wb < wbs; wb++) begin
      for (int r = 0; r < rows; r++) begin
        wait_tile_start();
        check("tile_row", tile_row, r);
        check("tile_wb", tile_wb, wb);
        @(negedge clk);
        check("tile_start_one_cycle", tile_start, 0);
        check("tile_row_hold", tile_row, r);
        if (idx == abort_idx) begin
          abort = 1'b1;
          tile_done = with_done;
          @(negedge clk);
          abort = 1'b0;
          tile_done = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_no_done", job_done, 0);
          @(negedge clk);
          check("abort_no_done_later", job_done, 0);
          check("abort_ready", job_ready, 1);
          return;
        end
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        if (wb == wbs - 1 && r == rows - 1) begin
          check("job_done", job_done, 1);
          @(negedge clk);
          check("job_done_pulse", job_done, 0);
          check("ready_after_done", job_ready, 1);
        end else begin
          check("job_done_early", job_done, 0);
        end
        idx++;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_pp_rstn", pp_rstn, 0);
    check("rst_pp_start", pp_start, 0);
    check("rst_busy", busy, 0);
    check("rst_tile_start", tile_start, 0);
    check("rst_tile_row", tile_row, 0);
    check("rst_pp_tensor", pp_tensor_size, 0);
    rst = 1'b0;
    @(negedge clk);
    tile_done = 1'b1;
    repeat (2) @(negedge clk);
    tile_done = 1'b0;
    check("stray_done_busy", busy, 0);
    check("stray_done_tile", tile_start, 0);

    // Kernel larger than tensor is rejected.
    start_job(5, 7, 1, 1, 8);
    check("check_busy", busy, 1);
    check("check_ready_low", job_ready, 0);
    @(negedge clk);
    check("err_param_pulse", err_param, 1);
    check("err_param_no_start", pp_start, 0);
    check("err_param_ready", job_ready, 1);
    @(negedge clk);
    check("err_param_one_cycle", err_param, 0);
    start_job(5, 3, 1, 0, 8);
    @(negedge clk);
    check("err_param_stride0", err_param, 1);
    @(negedge clk);

    // Single weight block: three rows, with the CLEAR window measured.
    start_job(5, 3, 1, 1, 8);
    check("check_pp_rstn", pp_rstn, 1);
    check("latched_tensor", pp_tensor_size, 5);
    check("latched_knums", pp_kernel_nums, 8);
    @(negedge clk);
    check("clear_cycle1", pp_rstn, 0);
    @(negedge clk);
    check("clear_cycle2", pp_rstn, 0);
    @(negedge clk);
    check("prep_pp_rstn", pp_rstn, 1);
    check("prep_pp_start", pp_start, 1);
    run_tiles(3, 1, -1, 1'b0);

    // Three weight blocks: nine tiles.
    start_job(5, 3, 1, 1, 20);
    run_tiles(3, 3, -1, 1'b0);

    // Abort while waiting on the second tile, then a clean job.
    start_job(5, 3, 1, 1, 8);
    run_tiles(3, 1, 1, 1'b0);
    start_job(5, 3, 1, 1, 8);
    run_tiles(3, 1, -1, 1'b0);

    // Abort coinciding with the last tile_done.
    start_job(5, 3, 1, 1, 8);
    run_tiles(3, 1, 2, 1'b1);

    // Zero weight block rows: straight to DONE, no tiles.
    force_wbrn0 = 1'b1;
    start_job(5, 3, 1, 1, 8);
    n = 0;
    seen = 1'b0;
    while (job_done !== 1'b1 && n < 100) begin
      if (tile_start === 1'b1) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("wbrn0_job_done", job_done, 1);
    check("wbrn0_no_tiles", seen, 0);
    force_wbrn0 = 1'b0;
    @(negedge clk);

    // Preparation never completes.
    prep_allow = 1'b0;
    start_job(5, 3, 1, 1, 8);
    n = 0;
    while (pp_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_prep_entry", pp_start, 1);
    repeat (255) @(negedge clk);
    check("timeout_not_yet", err_timeout, 0);
    check("timeout_still_prep", pp_start, 1);
    @(negedge clk);
    check("timeout_pulse", err_timeout, 1);
    check("timeout_pp_rstn", pp_rstn, 0);
    check("timeout_ready", job_ready, 1);
    @(negedge clk);
    check("timeout_one_cycle", err_timeout, 0);
    prep_allow = 1'b1;

    // Reset during ISSUE of the second tile.
    start_job(5, 3, 1, 1, 8);
    wait_tile_start();
    @(negedge clk);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    check("second_issue_row", tile_row, 1);
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    abort = 1'b0;
    check("midrst_tile_start", tile_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", job_ready, 1);
    check("midrst_pp_rstn", pp_rstn, 0);
    check("midrst_pp_start", pp_start, 0);
    check("midrst_tile_row", tile_row, 0);
    check("midrst_pp_tensor", pp_tensor_size, 0);
    @(negedge clk);
    check("after_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
